// File: rtl/bf_round_sequencer_pkg.sv
// Shared types and helpers for the Bellman-Ford round sequencer.
// Provides the FSM state enum, step constants and the run-length helper.
package bf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ROLL,
        S_DRAIN,
        S_HOLD
    } bf_seq_state_t;

    localparam int BF_STEPS  = 4;
    localparam int BF_STEP_W = 2;

    // Cycles spent in LOAD+RUN+ROLL for one complete run.
    function automatic int bf_run_cycles(input int n, input int iter);
        return BF_STEPS * iter * (n + 1);
    endfunction

endpackage

// File: rtl/bf_round_sequencer_if.sv
// Result hand-off bundle: valid/ready handshake plus the captured distances.
// master drives out_valid/result_flat and samples out_ready; slave is the sink.
interface bf_round_sequencer_if #(
    parameter int N = 8,
    parameter int W = 32
);
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] result_flat;

    modport master (
        output out_valid,
        output result_flat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  result_flat,
        output out_ready
    );
endinterface

// File: rtl/bf_round_sequencer.sv
// Sequencer driving the Bellman-Ford array: load, 4 steps x ITER rounds of
// N phases, drain, capture d_flat and hand it off over res (valid/ready).
// Ports: clk, rst_global_n, start, abort, d_flat in; strobes, counters, busy out.
module bf_round_sequencer
    import bf_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int ITER  = N - 1,
    parameter int DRAIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_global_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N*W-1:0]       d_flat,
    output logic                 read_enable_global,
    output logic                 rollover_phase_counter,
    output logic                 phase_counter,
    output logic [BF_STEP_W-1:0] step_counter,
    output logic                 busy,
    bf_round_sequencer_if.master res
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (ITER > 0) ? $clog2(ITER + 1) : 1;
    localparam int DW = $clog2(DRAIN + 1);

    localparam logic [PW-1:0]        P_LAST = PW'(N - 1);
    localparam logic [IW-1:0]        I_LAST = IW'(ITER - 1);
    localparam logic [DW-1:0]        D_LAST = DW'(DRAIN - 1);
    localparam logic [BF_STEP_W-1:0] S_LAST = BF_STEP_W'(BF_STEPS - 1);

    bf_seq_state_t  state;
    logic [PW-1:0]  p;
    logic [IW-1:0]  iter;
    logic [DW-1:0]  dcnt;
    logic           out_valid;
    logic [N*W-1:0] result_flat;

    // Final phase of the final step of the final iteration.
    logic last_round;
    assign last_round = (iter == I_LAST) && (step_counter == S_LAST);

    assign res.out_valid   = out_valid;
    assign res.result_flat = result_flat;

    always_ff @(posedge clk or negedge rst_global_n) begin
        if (!rst_global_n) begin
            state                  <= S_IDLE;
            p                      <= '0;
            iter                   <= '0;
            dcnt                   <= '0;
            read_enable_global     <= 1'b0;
            rollover_phase_counter <= 1'b0;
            phase_counter          <= 1'b0;
            step_counter           <= '0;
            busy                   <= 1'b0;
            out_valid              <= 1'b0;
            result_flat            <= '0;
        end else if (state != S_IDLE && abort) begin
            // Cancel wins over everything; the last result is kept.
            state                  <= S_IDLE;
            p                      <= '0;
            iter                   <= '0;
            dcnt                   <= '0;
            read_enable_global     <= 1'b0;
            rollover_phase_counter <= 1'b0;
            phase_counter          <= 1'b0;
            step_counter           <= '0;
            busy                   <= 1'b0;
            out_valid              <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state              <= S_LOAD;
                        read_enable_global <= 1'b1;
                        busy               <= 1'b1;
                        p                  <= '0;
                        iter               <= '0;
                        dcnt               <= '0;
                        step_counter       <= '0;
                        phase_counter      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    read_enable_global <= 1'b0;
                    p                  <= '0;
                    phase_counter      <= 1'b0;
                    state              <= S_RUN;
                end
                S_RUN: begin
                    if (p == P_LAST) begin
                        p             <= '0;
                        phase_counter <= 1'b0;
                        if (last_round) begin
                            dcnt  <= '0;
                            state <= S_DRAIN;
                        end else begin
                            rollover_phase_counter <= 1'b1;
                            state                  <= S_ROLL;
                        end
                    end else begin
                        // N is even, so toggling tracks p[0].
                        p             <= p + 1'b1;
                        phase_counter <= ~phase_counter;
                    end
                end
                S_ROLL: begin
                    rollover_phase_counter <= 1'b0;
                    step_counter           <= step_counter + 1'b1;
                    if (step_counter == S_LAST) begin
                        iter <= iter + 1'b1;
                    end
                    p             <= '0;
                    phase_counter <= 1'b0;
                    state         <= S_RUN;
                end
                S_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        result_flat <= d_flat;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res.out_ready) begin
                        out_valid    <= 1'b0;
                        busy         <= 1'b0;
                        step_counter <= '0;
                        iter         <= '0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_round_sequencer.sv
// Self-checking bench for bf_round_sequencer (N=4, ITER=1, DRAIN=2).
// A cycle-position reference model is compared against the DUT every cycle.
module tb_bf_round_sequencer;
    import bf_pkg::*;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int ITER   = 1;
    localparam int DRAIN  = 2;
    localparam int NW     = N * W;
    localparam int LRUN   = bf_run_cycles(N, ITER);
    localparam int HOLD_C = LRUN + DRAIN + 1;

    logic          clk = 1'b0;
    logic          rst_global_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NW-1:0] d_flat = '0;
    logic          read_enable_global;
    logic          rollover_phase_counter;
    logic          phase_counter;
    logic [1:0]    step_counter;
    logic          busy;

    int tests = 0;
    int fails = 0;

    bf_round_sequencer_if #(.N(N), .W(W)) rif ();

    bf_round_sequencer #(
        .N(N), .W(W), .ITER(ITER), .DRAIN(DRAIN)
    ) dut (
        .clk                    (clk),
        .rst_global_n           (rst_global_n),
        .start                  (start),
        .abort                  (abort),
        .d_flat                 (d_flat),
        .read_enable_global     (read_enable_global),
        .rollover_phase_counter (rollover_phase_counter),
        .phase_counter          (phase_counter),
        .step_counter           (step_counter),
        .busy                   (busy),
        .res                    (rif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [NW-1:0] act,
                       input logic [NW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] rnd_d();
        return {$urandom, $urandom};
    endfunction

    // Reference model: position within a run, counted from the start edge.
    bit            m_act = 1'b0;
    int            m_c = 0;
    bit            m_step0 = 1'b1;
    logic [NW-1:0] m_res = '0;

    always @(posedge clk or negedge rst_global_n) begin
        if (!rst_global_n) begin
            m_act   = 1'b0;
            m_c     = 0;
            m_res   = '0;
            m_step0 = 1'b1;
        end else if (!m_act) begin
            if (start) begin
                m_act   = 1'b1;
                m_c     = 1;
                m_step0 = 1'b0;
            end
        end else if (abort) begin
            m_act   = 1'b0;
            m_step0 = 1'b1;
        end else if (m_c >= HOLD_C) begin
            if (rif.out_ready) m_act = 1'b0;
        end else begin
            m_c++;
            if (m_c == HOLD_C) m_res = d_flat;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin : cmp
        int  k;
        int  pos;
        bit  in_run;
        bit  e_roll;
        bit  e_phase;
        int  e_step;
        if (rst_global_n && chk_en) begin
            in_run  = m_act && m_c >= 2 && m_c <= LRUN;
            k       = m_c - 2;
            pos     = k % (N + 1);
            e_roll  = in_run && pos == N;
            e_phase = in_run && pos < N && (pos % 2) == 1;
            e_step  = (k / (N + 1)) % BF_STEPS;
            chk("busy", busy, m_act);
            chk("rd_en", read_enable_global, m_act && m_c == 1);
            chk("roll", rollover_phase_counter, e_roll);
            chk("phase", phase_counter, e_phase);
            chk("valid", rif.out_valid, m_act && m_c >= HOLD_C);
            chk("result", rif.result_flat, m_res);
            if (in_run) chk("step_run", step_counter, e_step);
            else if (m_act && m_c == 1) chk("step_load", step_counter, 0);
            else if (!m_act && m_step0) chk("step_idle", step_counter, 0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, read_enable_global, 0);
        chk({tag, "_roll"}, rollover_phase_counter, 0);
        chk({tag, "_phase"}, phase_counter, 0);
        chk({tag, "_step"}, step_counter, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, rif.out_valid, 0);
        chk({tag, "_result"}, rif.result_flat, 0);
    endtask

    // Start-pulse run with ready high; pins the schedule with literals.
    task automatic run_basic(input string tag);
        logic [NW-1:0] d_hist [0:31];
        int rd_cnt;
        int rd_first;
        int rolls [$];
        int fv;
        rd_cnt   = 0;
        rd_first = 0;
        fv       = 0;
        rif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            d_flat    = rnd_d();
            d_hist[c] = d_flat;
            @(negedge clk);
            if (read_enable_global) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = c;
            end
            if (rollover_phase_counter) rolls.push_back(c);
            if (rif.out_valid && fv == 0) begin
                fv = c;
                chk({tag, "_capture"}, rif.result_flat, d_hist[22]);
            end
            tick();
        end
        chk({tag, "_rd_count"}, rd_cnt, 1);
        chk({tag, "_rd_cycle"}, rd_first, 1);
        chk({tag, "_roll_count"}, rolls.size(), 3);
        if (rolls.size() == 3) begin
            chk({tag, "_roll0"}, rolls[0], 6);
            chk({tag, "_roll1"}, rolls[1], 11);
            chk({tag, "_roll2"}, rolls[2], 16);
        end
        chk({tag, "_valid_cycle"}, fv, 23);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rif.out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!rif.out_valid) chk({tag, "_wait_valid"}, 0, 1);
    endtask

    initial begin
        rif.out_ready = 1'b1;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst_global_n = 1'b1;
        chk_en = 1'b1;
        tick();

        run_basic("basic");

        // Backpressure in HOLD with d_flat moving underneath.
        rif.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            d_flat = rnd_d();
            tick();
            chk("bp_valid_held", rif.out_valid, 1);
        end
        rif.out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_busy_after", busy, 0);
        tick();

        // start held high: one run, next LOAD right after the idle cycle.
        begin
            int rd_c [$];
            start = 1'b1;
            tick();
            for (int c = 1; c <= 26; c++) begin
                d_flat = rnd_d();
                @(negedge clk);
                if (read_enable_global) rd_c.push_back(c);
                tick();
            end
            start = 1'b0;
            chk("hold_start_loads", rd_c.size(), 2);
            if (rd_c.size() == 2) chk("second_load_cycle", rd_c[1], 25);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            tick();
        end

        // Abort during step 2 of the run.
        begin
            int n;
            bit rose;
            n = 0;
            rose = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (step_counter != 2'd2 && n < 100) begin
                tick();
                n++;
            end
            chk("abort_reach_step2", step_counter, 2);
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            @(negedge clk);
            chk("abort_step", step_counter, 0);
            chk("abort_busy", busy, 0);
            for (int i = 0; i < 30; i++) begin
                tick();
                if (rif.out_valid) rose = 1'b1;
            end
            chk("abort_no_valid", rose, 0);
        end

        // Abort and ready together in HOLD.
        rif.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("ab_hold");
        d_flat = rnd_d();
        abort = 1'b1;
        rif.out_ready = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_hold_valid", rif.out_valid, 0);
        chk("ab_hold_busy", busy, 0);
        tick();

        // Asynchronous reset in the middle of a ROLL cycle.
        begin
            int n;
            n = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            @(negedge clk);
            while (!rollover_phase_counter && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_roll", rollover_phase_counter, 1);
            #2;
            rst_global_n = 1'b0;
            #1;
            chk_all_zero("async_rst");
            tick();
            rst_global_n = 1'b1;
            tick();
        end
        run_basic("after_rst");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            start         = ($urandom_range(0, 7) == 0);
            abort         = ($urandom_range(0, 99) == 0);
            rif.out_ready = ($urandom_range(0, 2) != 0);
            d_flat        = rnd_d();
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
